// File: rtl/wb_id_arb_pkg.sv
// Shared types and constants for the I/D Wishbone arbiter.
// Holds the FSM state encoding, master ids, bus widths and the request payload.
package wb_id_arb_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    localparam logic M_I = 1'b0;
    localparam logic M_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    // Request side of one master as seen by the slave port
    typedef struct packed {
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] datw;
    } wb_req_t;

    // Winner among the requesting masters; a tie goes to the one not granted last
    function automatic logic pick_master(input logic req_i, input logic req_d,
                                         input logic last);
        if (req_i && req_d) begin
            return (last == M_D) ? M_I : M_D;
        end
        return req_i ? M_I : M_D;
    endfunction

endpackage

// File: rtl/wb_wait_timer.sv
// Wait counter for a granted transfer; saturates at TIMEOUT_CYCLES and
// flags expiry while it sits there.
module wb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/wb_id_arb.sv
// Merges the instruction and data classic-Wishbone masters onto one
// single-transfer slave port with alternating-priority arbitration and a timeout.
module wb_id_arb
    import wb_id_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_cyc,
    input  logic             i_stb,
    input  logic [ADR_W-1:0] i_adr,
    output logic             i_ack,
    output logic             i_err,
    output logic [DAT_W-1:0] i_datr,

    input  logic             d_cyc,
    input  logic             d_stb,
    input  logic             d_we,
    input  logic [SEL_W-1:0] d_sel,
    input  logic [ADR_W-1:0] d_adr,
    input  logic [DAT_W-1:0] d_datw,
    output logic             d_ack,
    output logic             d_err,
    output logic [DAT_W-1:0] d_datr,

    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [SEL_W-1:0] s_sel,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_datw,
    input  logic             s_ack,
    input  logic [DAT_W-1:0] s_datr
);

    state_t  state, state_nxt;
    logic    last, last_nxt;
    logic    req_i, req_d, winner;
    logic    timer_clr, timer_en, expired;
    wb_req_t bus_i, bus_d, bus_s;

    assign req_i  = i_cyc & i_stb;
    assign req_d  = d_cyc & d_stb;
    assign winner = pick_master(req_i, req_d, last);

    // The I master only reads whole words
    assign bus_i = '{we: 1'b0, sel: {SEL_W{1'b1}}, adr: i_adr, datw: '0};
    assign bus_d = '{we: d_we, sel: d_sel, adr: d_adr, datw: d_datw};

    wb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            last  <= M_D;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next state, arbitration and slave-port muxing
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        bus_s     = '0;
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        i_ack     = 1'b0;
        i_err     = 1'b0;
        i_datr    = '0;
        d_ack     = 1'b0;
        d_err     = 1'b0;
        d_datr    = '0;

        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (req_i || req_d) begin
                    state_nxt = (winner == M_I) ? GNT_I : GNT_D;
                    last_nxt  = winner;
                end
            end
            GNT_I: begin
                s_cyc    = 1'b1;
                s_stb    = 1'b1;
                bus_s    = bus_i;
                i_ack    = s_ack;
                i_datr   = s_datr;
                i_err    = i_cyc & expired & ~s_ack;
                timer_en = ~s_ack;
                if (s_ack || !i_cyc || expired) begin
                    state_nxt = IDLE;
                end
            end
            GNT_D: begin
                s_cyc    = 1'b1;
                s_stb    = 1'b1;
                bus_s    = bus_d;
                d_ack    = s_ack;
                d_datr   = s_datr;
                d_err    = d_cyc & expired & ~s_ack;
                timer_en = ~s_ack;
                if (s_ack || !d_cyc || expired) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign s_we   = bus_s.we;
    assign s_sel  = bus_s.sel;
    assign s_adr  = bus_s.adr;
    assign s_datw = bus_s.datw;

endmodule

// File: tb/tb_wb_id_arb.sv
// Cycle-by-cycle vector bench for wb_id_arb with a response scoreboard.
module tb_wb_id_arb;

    localparam int unsigned TO = 4;
    localparam int GX = 0;
    localparam int GI = 1;
    localparam int GD = 2;

    typedef struct packed {
        logic        scyc;
        logic        sstb;
        logic        swe;
        logic [3:0]  ssel;
        logic [31:0] sadr;
        logic [31:0] sdatw;
        logic        iack;
        logic        ierr;
        logic [31:0] idatr;
        logic        dack;
        logic        derr;
        logic [31:0] ddatr;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iadr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dsel;
        logic [31:0] dadr;
        logic [31:0] ddat;
        logic        sack;
        logic [31:0] sdat;
        exp_t        exp;
    } vec_t;

    typedef struct packed {
        logic        m;
        logic        err;
        logic [31:0] dat;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cyc, i_stb, i_ack, i_err;
    logic [31:0] i_adr, i_datr;
    logic        d_cyc, d_stb, d_we, d_ack, d_err;
    logic [3:0]  d_sel;
    logic [31:0] d_adr, d_datw, d_datr;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_datw, s_datr;

    int    errors = 0;
    int    checks = 0;
    logic  mon_en = 1'b0;
    vec_t  tbl[$];
    exp_t  exp_q[$];
    resp_t resp_q[$];

    always #5 clk = ~clk;

    wb_id_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_adr(i_adr),
        .i_ack(i_ack), .i_err(i_err), .i_datr(i_datr),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel),
        .d_adr(d_adr), .d_datw(d_datw),
        .d_ack(d_ack), .d_err(d_err), .d_datr(d_datr),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_datw(s_datw), .s_ack(s_ack), .s_datr(s_datr)
    );

    // g names the master expected on the slave port this cycle
    function automatic vec_t mk(input int r, input int ir, input logic [31:0] ia,
                                input int dr, input int dw, input logic [3:0] ds,
                                input logic [31:0] da, input logic [31:0] dd,
                                input int sa, input logic [31:0] sd,
                                input int g, input int ak, input int er);
        vec_t v;
        v.rst = 1'(r);  v.ireq = 1'(ir); v.iadr = ia;
        v.dreq = 1'(dr); v.dwe = 1'(dw); v.dsel = ds; v.dadr = da; v.ddat = dd;
        v.sack = 1'(sa); v.sdat = sd;
        v.exp = '0;
        if (g == GI) begin
            v.exp.scyc = 1'b1; v.exp.sstb = 1'b1; v.exp.swe = 1'b0;
            v.exp.ssel = 4'hF; v.exp.sadr = ia; v.exp.sdatw = 32'h0;
            v.exp.iack = 1'(ak); v.exp.ierr = 1'(er); v.exp.idatr = sd;
        end else if (g == GD) begin
            v.exp.scyc = 1'b1; v.exp.sstb = 1'b1; v.exp.swe = 1'(dw);
            v.exp.ssel = ds; v.exp.sadr = da; v.exp.sdatw = dd;
            v.exp.dack = 1'(ak); v.exp.derr = 1'(er); v.exp.ddatr = sd;
        end
        return v;
    endfunction

    // Any ack or err must match the next response the vectors promised
    always @(negedge clk) begin
        resp_t got, want;
        #2;
        if (mon_en && (i_ack || i_err || d_ack || d_err)) begin
            got.m   = d_ack | d_err;
            got.err = i_err | d_err;
            got.dat = (d_ack | d_err) ? d_datr : i_datr;
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got m=%0d err=%0d dat=%h, required none",
                         got.m, got.err, got.dat);
            end else begin
                want = resp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL resp: got m=%0d err=%0d dat=%h, required m=%0d err=%0d dat=%h",
                             got.m, got.err, got.dat, want.m, want.err, want.dat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e, got;

        // Reset, then a lone D write acked two cycles after grant
        tbl.push_back(mk(0,0,'h0,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,0,'h0,1,1,4'h3,'h1000,32'hDEADBEEF,1,'h0,GX,0,0));
        tbl.push_back(mk(1,0,'h0,1,1,4'h3,'h1000,32'hDEADBEEF,0,'h0,GD,0,0));
        tbl.push_back(mk(1,0,'h0,1,1,4'h3,'h1000,32'hDEADBEEF,0,'h0,GD,0,0));
        tbl.push_back(mk(1,0,'h0,1,1,4'h3,'h1000,32'hDEADBEEF,1,'hA5A50000,GD,1,0));
        tbl.push_back(mk(1,0,'h0,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        // Both held: grants alternate I, D, I, D with an idle cycle between
        tbl.push_back(mk(1,1,'h100,1,0,4'hF,'h2000,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h100,1,0,4'hF,'h2000,'h0,1,'h11,GI,1,0));
        tbl.push_back(mk(1,1,'h100,1,0,4'hF,'h2000,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h100,1,0,4'hF,'h2000,'h0,1,'h22,GD,1,0));
        tbl.push_back(mk(1,1,'h100,1,0,4'hF,'h2000,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h100,1,0,4'hF,'h2000,'h0,1,'h33,GI,1,0));
        tbl.push_back(mk(1,1,'h100,1,0,4'hF,'h2000,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h100,1,0,4'hF,'h2000,'h0,1,'h44,GD,1,0));
        tbl.push_back(mk(1,0,'h0,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        // I read acked in the first grant cycle; unaligned low bits pass through
        tbl.push_back(mk(1,1,'h103,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h103,0,0,4'h0,'h0,'h0,1,32'h48000000,GI,1,0));
        tbl.push_back(mk(1,1,'h103,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h103,0,0,4'h0,'h0,'h0,1,'h77,GI,1,0));
        tbl.push_back(mk(1,0,'h0,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        // D timeout at wait count 4, then an I request served normally
        tbl.push_back(mk(1,0,'h0,1,0,4'hF,'h3000,'h0,0,'h0,GX,0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,0,'h0,1,0,4'hF,'h3000,'h0,0,'h0,GD,0,0));
        tbl.push_back(mk(1,1,'h200,1,0,4'hF,'h3000,'h0,0,'h0,GD,0,1));
        tbl.push_back(mk(1,1,'h200,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h200,0,0,4'h0,'h0,'h0,1,'h99,GI,1,0));
        tbl.push_back(mk(1,0,'h0,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        // s_ack coinciding with the timeout wins
        tbl.push_back(mk(1,0,'h0,1,0,4'hF,'h3004,'h0,0,'h0,GX,0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,0,'h0,1,0,4'hF,'h3004,'h0,0,'h0,GD,0,0));
        tbl.push_back(mk(1,0,'h0,1,0,4'hF,'h3004,'h0,1,'hAB,GD,1,0));
        tbl.push_back(mk(1,0,'h0,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        // D drops cyc mid-grant; pending I granted after one idle cycle
        tbl.push_back(mk(1,0,'h0,1,1,4'hC,'h5000,'h1234,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h300,1,1,4'hC,'h5000,'h1234,0,'h0,GD,0,0));
        tbl.push_back(mk(1,1,'h300,0,1,4'hC,'h5000,'h1234,0,'h0,GD,0,0));
        tbl.push_back(mk(1,1,'h300,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h300,0,0,4'h0,'h0,'h0,1,'hCD,GI,1,0));
        tbl.push_back(mk(1,0,'h0,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));
        // Reset during GNT_D, then during GNT_I; ties after release go to I
        tbl.push_back(mk(1,0,'h0,1,0,4'hF,'h4000,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,0,'h0,1,0,4'hF,'h4000,'h0,0,'h0,GD,0,0));
        tbl.push_back(mk(0,0,'h0,1,0,4'hF,'h4000,'h0,0,'h0,GD,0,0));
        tbl.push_back(mk(1,1,'h400,1,0,4'hF,'h4000,'h0,1,'h55,GX,0,0));
        tbl.push_back(mk(1,1,'h400,1,0,4'hF,'h4000,'h0,0,'h0,GI,0,0));
        tbl.push_back(mk(0,1,'h400,1,0,4'hF,'h4000,'h0,0,'h0,GI,0,0));
        tbl.push_back(mk(1,1,'h400,1,0,4'hF,'h4000,'h0,0,'h0,GX,0,0));
        tbl.push_back(mk(1,1,'h400,1,0,4'hF,'h4000,'h0,1,'h66,GI,1,0));
        tbl.push_back(mk(1,0,'h0,0,0,4'h0,'h0,'h0,0,'h0,GX,0,0));

        rst = 1'b0; i_cyc = 1'b0; i_stb = 1'b0; i_adr = '0;
        d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_sel = '0; d_adr = '0; d_datw = '0;
        s_ack = 1'b0; s_datr = '0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst    = tbl[k].rst;
            i_cyc  = tbl[k].ireq; i_stb = tbl[k].ireq; i_adr = tbl[k].iadr;
            d_cyc  = tbl[k].dreq; d_stb = tbl[k].dreq; d_we = tbl[k].dwe;
            d_sel  = tbl[k].dsel; d_adr = tbl[k].dadr; d_datw = tbl[k].ddat;
            s_ack  = tbl[k].sack; s_datr = tbl[k].sdat;
            exp_q.push_back(tbl[k].exp);
            if (tbl[k].exp.iack || tbl[k].exp.ierr)
                resp_q.push_back('{m: 1'b0, err: tbl[k].exp.ierr, dat: tbl[k].exp.idatr});
            if (tbl[k].exp.dack || tbl[k].exp.derr)
                resp_q.push_back('{m: 1'b1, err: tbl[k].exp.derr, dat: tbl[k].exp.ddatr});
            #1;
            got = '{scyc: s_cyc, sstb: s_stb, swe: s_we, ssel: s_sel, sadr: s_adr,
                    sdatw: s_datw, iack: i_ack, ierr: i_err, idatr: i_datr,
                    dack: d_ack, derr: d_err, ddatr: d_datr};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL vec%0d: got cyc=%b stb=%b we=%b sel=%h adr=%h datw=%h ia=%b ie=%b idr=%h da=%b de=%b ddr=%h; required cyc=%b stb=%b we=%b sel=%h adr=%h datw=%h ia=%b ie=%b idr=%h da=%b de=%b ddr=%h",
                         k, got.scyc, got.sstb, got.swe, got.ssel, got.sadr, got.sdatw,
                         got.iack, got.ierr, got.idatr, got.dack, got.derr, got.ddatr,
                         e.scyc, e.sstb, e.swe, e.ssel, e.sadr, e.sdatw,
                         e.iack, e.ierr, e.idatr, e.dack, e.derr, e.ddatr);
            end
        end

        @(negedge clk);
        #3;
        checks++;
        if (resp_q.size() != 0) begin
            errors++;
            $display("FAIL resp_drain: got %0d responses still pending, required 0", resp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_id_arb.md
WB_ID_ARB -- requirements
Module: wb_id_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles a granted transfer may wait for s_ack before it is aborted with an error.
REQ-002 clk  in  1  sole clock; every flop samples on its rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 i_cyc, i_stb  in  1 each  instruction-master cycle and strobe.
REQ-005 i_adr  in  32  instruction-master byte address.
REQ-006 i_ack, i_err  out  1 each  instruction-master acknowledge and error.
REQ-007 i_datr  out  32  instruction-master read data.
REQ-008 d_cyc, d_stb, d_we  in  1 each  data-master cycle, strobe and write enable.
REQ-009 d_sel  in  4  data-master byte selects.
REQ-010 d_adr, d_datw  in  32 each  data-master address and write data.
REQ-011 d_ack, d_err  out  1 each  data-master acknowledge and error.
REQ-012 d_datr  out  32  data-master read data.
REQ-013 s_cyc, s_stb, s_we  out  1 each  slave-port cycle, strobe and write enable.
REQ-014 s_sel  out  4  slave-port byte selects.
REQ-015 s_adr, s_datw  out  32 each  slave-port address and write data.
REQ-016 s_ack  in  1  slave acknowledge.
REQ-017 s_datr  in  32  slave read data.

Function
REQ-018 The block merges the I and D classic-Wishbone buses from the bridge onto one single-transfer slave port; FSM states are IDLE, GNT_I, GNT_D.
REQ-019 A request means cyc&stb; IDLE->GNT_I or IDLE->GNT_D on the cycle after a request is sampled, so grant latency is 1 cycle.
REQ-020 When one master requests in IDLE, it is granted; when both request, the master not granted most recently wins; the last-granted flag resets to D, so I wins the first tie.
REQ-021 In GNT_x, s_cyc=s_stb=1; s_adr, s_we, s_sel and s_datw follow master x combinationally; s_we=0 and s_sel=4'hF when x=I.
REQ-022 In IDLE, s_cyc=s_stb=s_we=0 and s_sel, s_adr and s_datw are 0.
REQ-023 In GNT_x, x_ack=s_ack combinationally and x_datr=s_datr; the other master's ack/err stay 0; s_ack in IDLE is ignored.
REQ-024 When s_ack=1 in GNT_x, the FSM returns to IDLE next cycle; there is no back-to-back grant, so each transfer takes at least 2 cycles.
REQ-025 When master x drops cyc while in GNT_x without s_ack, the transfer aborts: IDLE next cycle, no ack or err to x.
REQ-026 A wait counter clears on entry to GNT_x and increments each GNT cycle without s_ack.
REQ-027 When the wait counter equals TIMEOUT_CYCLES, x_err=1 for that one cycle, x_ack=0, and the FSM goes to IDLE next cycle.
REQ-028 When s_ack and timeout coincide, s_ack wins and no err is issued.
REQ-029 The wait counter is $clog2(TIMEOUT_CYCLES+1) bits wide and never wraps.
REQ-030 An I-port address is forwarded unchanged; bits [1:0] are passed through as delivered by the bridge, which are 0 for word-aligned addresses.

Reset
REQ-031 When rst=0 at a clock edge, the FSM goes to IDLE, the wait counter clears and the last-granted flag becomes D.
REQ-032 After reset, all outputs take their IDLE values: every ack/err=0, s_cyc=s_stb=0 and all data=0.
REQ-033 Reset asserted mid-transfer drops s_cyc on the next edge and delivers no ack or err to either master.

Structure
REQ-034 The shared package holds the FSM state enum (IDLE, GNT_I, GNT_D), the master-id constants (M_I=0, M_D=1) and the 32-bit address/data width constants.
REQ-035 The wait counter is a single sub-module wb_wait_timer with ports clk, rst, clr, en and expired, parameterised by TIMEOUT_CYCLES.
REQ-036 The FSM, arbitration and muxing stay in wb_id_arb; the target is 150-250 lines of RTL.

Verification
REQ-037 Lone D write: d_adr=0x1000, d_datw=0xDEADBEEF, d_sel=4'h3, slave acks 2 cycles after grant -> slave port carries those values with s_we=1; d_ack pulses once; i_ack stays 0.
REQ-038 Simultaneous I and D requests out of reset -> I is granted first (s_adr=i_adr), then D; with both held, grants alternate I, D, I, D.
REQ-039 I read with s_datr=0x48000000 and s_ack in the first grant cycle -> i_ack and i_datr=0x48000000 in the cycle after the request; IDLE on the next cycle.
REQ-040 Slave never acks with TIMEOUT_CYCLES=4 -> d_err pulses exactly 1 cycle at the 4th wait count; s_cyc drops the next cycle; a later I request is granted normally.
REQ-041 rst=0 during GNT_D -> s_cyc=0 and d_ack=d_err=0 after the edge; the first tie after release is granted to I.
REQ-042 D drops cyc mid-grant -> IDLE next cycle, no d_ack/d_err, and a pending I request is granted on the following cycle.
